// File: rtl/async_block_fifo_pkg.sv
// Shared types and helpers for async_block_fifo: block-assembly states and Gray-code conversion.
package async_fifo_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } blk_state_t;

  // Word 0 of every block lands in the most significant WORD_W bits of the header.
  localparam bit WORD0_IN_MSBS = 1'b1;

  localparam int PTR_MAX_W = 32;

  // Callers zero-extend narrower pointers to PTR_MAX_W and truncate the result back.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_block_fifo_if.sv
// Host-word / miner-block handshake bundle for async_block_fifo.
interface async_block_fifo_if #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int DROP_CNT_W      = 16
);
  localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK;
  localparam int FILL_W  = $clog2(WORDS_PER_BLOCK + 1);

  logic                  wr_en;
  logic [WORD_W-1:0]     data_in;
  logic                  fifo_full;
  logic [DROP_CNT_W-1:0] wr_drop_cnt;
  logic                  rd_en;
  logic [BLOCK_W-1:0]    block_header;
  logic                  block_ready;
  logic                  fifo_empty;
  logic [FILL_W-1:0]     fill_cnt;

  modport master (
    output wr_en, data_in, rd_en,
    input  fifo_full, wr_drop_cnt, block_header, block_ready, fifo_empty, fill_cnt
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output fifo_full, wr_drop_cnt, block_header, block_ready, fifo_empty, fill_cnt
  );

endinterface

// File: rtl/async_block_fifo_sync_ff_bus.sv
// Multi-flop synchroniser for Gray pointers and reset-release; asserts RST_VAL asynchronously.
module sync_ff_bus #(
  parameter int WIDTH   = 1,
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= {WIDTH{RST_VAL}};
      end
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_block_fifo.sv
// Dual-clock word FIFO that packs WORDS_PER_BLOCK words into one block for the miner domain.
// Define ASYNC_BLOCK_FIFO_DROP_CNT_EN to enable the saturating refused-write counter.
module async_block_fifo
  import async_fifo_pkg::*;
#(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int DEPTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DROP_CNT_W      = 16
) (
  input logic                clk_wr,
  input logic                clk_rd,
  input logic                rst,
  async_block_fifo_if.slave  bus
);

  localparam int AW      = $clog2(DEPTH) + 1;
  localparam int IW      = AW - 1;
  localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK;
  localparam int FILL_W  = $clog2(WORDS_PER_BLOCK + 1);
  localparam int BIDX_W  = $clog2(BLOCK_W);

  logic wr_rst;
  logic rd_rst;

  sync_ff_bus #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wr_rst_sync (
    .clk (clk_wr),
    .rst (rst),
    .d_i (1'b0),
    .q_o (wr_rst)
  );

  sync_ff_bus #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rd_rst_sync (
    .clk (clk_rd),
    .rst (rst),
    .d_i (1'b0),
    .q_o (rd_rst)
  );

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, rd_gray_sync;
  logic [AW-1:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, wr_gray_sync;
  logic          fifo_full_q, fifo_full_d, wr_push;
  logic          fifo_empty_q, fifo_empty_d, rd_pop;

  sync_ff_bus #(.WIDTH(AW), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rd_ptr_sync (
    .clk (clk_wr),
    .rst (wr_rst),
    .d_i (rd_gray_q),
    .q_o (rd_gray_sync)
  );

  sync_ff_bus #(.WIDTH(AW), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_wr_ptr_sync (
    .clk (clk_rd),
    .rst (rd_rst),
    .d_i (wr_gray_q),
    .q_o (wr_gray_sync)
  );

  // Full when the write pointer sits exactly one lap ahead: top two Gray bits inverted.
  always_comb begin
    wr_push     = bus.wr_en && !fifo_full_q;
    wr_bin_d    = wr_bin_q + AW'(wr_push);
    wr_gray_d   = AW'(bin2gray(PTR_MAX_W'(wr_bin_d)));
    fifo_full_d = (wr_gray_d == {~rd_gray_sync[AW-1 -: 2], rd_gray_sync[AW-3:0]});
  end

  always_ff @(posedge clk_wr or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin_q    <= '0;
      wr_gray_q   <= '0;
      fifo_full_q <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      wr_gray_q   <= wr_gray_d;
      fifo_full_q <= fifo_full_d;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (wr_push) begin
      mem_q[wr_bin_q[IW-1:0]] <= bus.data_in;
    end
  end

`ifdef ASYNC_BLOCK_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.wr_en && fifo_full_q && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_wr or posedge wr_rst) begin
    if (wr_rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.wr_drop_cnt = drop_cnt_q;
`else
  assign bus.wr_drop_cnt = {DROP_CNT_W{1'b0}};
`endif

  blk_state_t         state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               block_ready_q, block_ready_d;
  logic [BIDX_W-1:0]  slot_lsb;
  logic [WORD_W-1:0]  rd_word;

  assign rd_word = mem_q[rd_bin_q[IW-1:0]];

  // Pops only in FILL; a consumed block returns to FILL without popping on the same edge.
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    block_d       = block_q;
    block_ready_d = block_ready_q;
    rd_pop        = 1'b0;
    slot_lsb      = BIDX_W'((WORD0_IN_MSBS ? (WORDS_PER_BLOCK - 1 - int'(fill_cnt_q))
                                            : int'(fill_cnt_q)) * WORD_W);
    case (state_q)
      FILL: begin
        if (!fifo_empty_q) begin
          rd_pop = 1'b1;
          block_d[slot_lsb +: WORD_W] = rd_word;
          if (fill_cnt_q == FILL_W'(WORDS_PER_BLOCK - 1)) begin
            state_d       = HOLD;
            block_ready_d = 1'b1;
            fill_cnt_d    = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.rd_en) begin
          state_d       = FILL;
          block_ready_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
    rd_bin_d     = rd_bin_q + AW'(rd_pop);
    rd_gray_d    = AW'(bin2gray(PTR_MAX_W'(rd_bin_d)));
    fifo_empty_d = (rd_gray_d == wr_gray_sync);
  end

  always_ff @(posedge clk_rd or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin_q      <= '0;
      rd_gray_q     <= '0;
      fifo_empty_q  <= 1'b1;
      state_q       <= FILL;
      fill_cnt_q    <= '0;
      block_q       <= '0;
      block_ready_q <= 1'b0;
    end else begin
      rd_bin_q      <= rd_bin_d;
      rd_gray_q     <= rd_gray_d;
      fifo_empty_q  <= fifo_empty_d;
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      block_q       <= block_d;
      block_ready_q <= block_ready_d;
    end
  end

  assign bus.fifo_full    = fifo_full_q;
  assign bus.fifo_empty   = fifo_empty_q;
  assign bus.fill_cnt     = fill_cnt_q;
  assign bus.block_header = block_q;
  assign bus.block_ready  = block_ready_q;

endmodule

// File: tb/tb_async_block_fifo.sv
// Directed self-checking bench for async_block_fifo; honours ASYNC_BLOCK_FIFO_DROP_CNT_EN.
module tb_async_block_fifo;

  localparam int WORD_W      = 32;
  localparam int WPB         = 16;
  localparam int DEPTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int DROP_CNT_W  = 16;
  localparam int BLOCK_W     = WORD_W * WPB;

  logic clk_wr = 1'b0;
  logic clk_rd = 1'b0;
  logic rst    = 1'b1;
  int   wrHalf = 5000;
  int   rdHalf = 13514;

  int total = 0;
  int bad   = 0;

  logic [WORD_W-1:0]  refQ[$];
  logic [BLOCK_W-1:0] expHdr;
  int sent, wcyc, blocks, rcyc, n, expDrop;

  async_block_fifo_if #(.WORD_W(WORD_W), .WORDS_PER_BLOCK(WPB), .DROP_CNT_W(DROP_CNT_W)) bus ();

  async_block_fifo #(
    .WORD_W          (WORD_W),
    .WORDS_PER_BLOCK (WPB),
    .DEPTH           (DEPTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DROP_CNT_W      (DROP_CNT_W)
  ) dut (
    .clk_wr (clk_wr),
    .clk_rd (clk_rd),
    .rst    (rst),
    .bus    (bus)
  );

  always begin
    #(wrHalf);
    clk_wr = ~clk_wr;
  end

  always begin
    #(rdHalf);
    clk_rd = ~clk_rd;
  end

  task automatic checkOutput(input string tag, input logic [BLOCK_W-1:0] obs,
                             input logic [BLOCK_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] packSeq(input logic [WORD_W-1:0] base);
    logic [BLOCK_W-1:0] h;
    h = '0;
    for (int k = 0; k < WPB; k++) begin
      h[(WPB-1-k)*WORD_W +: WORD_W] = base + WORD_W'(k);
    end
    return h;
  endfunction

  task automatic applyStimulus(input logic [WORD_W-1:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk_wr);
      bus.wr_en   = 1'b1;
      bus.data_in = base + WORD_W'(i);
    end
    @(negedge clk_wr);
    bus.wr_en = 1'b0;
  endtask

  task automatic waitReady(input string tag, input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk_rd);
      c++;
    end while (bus.block_ready !== 1'b1 && c < budget);
    checkOutput(tag, BLOCK_W'(bus.block_ready), BLOCK_W'(1));
  endtask

  task automatic resetDut();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk_rd);
    @(negedge clk_wr);
    rst = 1'b0;
    repeat (4) @(negedge clk_rd);
    repeat (4) @(negedge clk_wr);
  endtask

  initial begin
    #1_500_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef ASYNC_BLOCK_FIFO_DROP_CNT_EN
    expDrop = 8;
`else
    expDrop = 0;
`endif
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;

    // Reset values while rst is held
    repeat (3) @(negedge clk_rd);
    checkOutput("rst_full",  BLOCK_W'(bus.fifo_full),   BLOCK_W'(0));
    checkOutput("rst_drop",  BLOCK_W'(bus.wr_drop_cnt), BLOCK_W'(0));
    checkOutput("rst_hdr",   bus.block_header,          BLOCK_W'(0));
    checkOutput("rst_ready", BLOCK_W'(bus.block_ready), BLOCK_W'(0));
    checkOutput("rst_empty", BLOCK_W'(bus.fifo_empty),  BLOCK_W'(1));
    checkOutput("rst_fill",  BLOCK_W'(bus.fill_cnt),    BLOCK_W'(0));
    @(negedge clk_wr);
    rst = 1'b0;
    repeat (4) @(negedge clk_rd);

    // Test 1: one block of 0..15, then consume it
    applyStimulus(32'h0, 16);
    waitReady("t1_ready", 200);
    checkOutput("t1_hdr_top", BLOCK_W'(bus.block_header[BLOCK_W-1 -: WORD_W]), BLOCK_W'(0));
    checkOutput("t1_hdr_low", BLOCK_W'(bus.block_header[WORD_W-1:0]), BLOCK_W'(32'hF));
    checkOutput("t1_hdr",     bus.block_header, packSeq(32'h0));
    checkOutput("t1_fill",    BLOCK_W'(bus.fill_cnt), BLOCK_W'(0));
    checkOutput("t1_empty",   BLOCK_W'(bus.fifo_empty), BLOCK_W'(1));
    bus.rd_en = 1'b1;
    @(negedge clk_rd);
    bus.rd_en = 1'b0;
    checkOutput("t1_consumed", BLOCK_W'(bus.block_ready), BLOCK_W'(0));

    // Test 2: hold a block, fill storage to full, then refused writes
    applyStimulus(32'h100, 16);
    waitReady("t2_ready", 200);
    repeat (6) @(negedge clk_wr);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_wr);
      if (i == 31) checkOutput("t2_not_full", BLOCK_W'(bus.fifo_full), BLOCK_W'(0));
      bus.wr_en   = 1'b1;
      bus.data_in = 32'h200 + WORD_W'(i);
    end
    @(negedge clk_wr);
    checkOutput("t2_full", BLOCK_W'(bus.fifo_full), BLOCK_W'(1));
    bus.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_wr);
      bus.wr_en   = 1'b1;
      bus.data_in = 32'hDEAD_0000 + WORD_W'(i);
    end
    @(negedge clk_wr);
    bus.wr_en = 1'b0;
    checkOutput("t2_drop",     BLOCK_W'(bus.wr_drop_cnt), BLOCK_W'(expDrop));
    checkOutput("t2_hold_hdr", bus.block_header, packSeq(32'h100));
    checkOutput("t2_hold_fill", BLOCK_W'(bus.fill_cnt), BLOCK_W'(0));
    @(negedge clk_rd);
    bus.rd_en = 1'b1;
    @(negedge clk_rd);
    bus.rd_en = 1'b0;
    waitReady("t2_ready2", 200);
    checkOutput("t2_hdr2",  bus.block_header, packSeq(32'h200));
    checkOutput("t2_empty", BLOCK_W'(bus.fifo_empty), BLOCK_W'(0));
    repeat (6) @(negedge clk_wr);
    checkOutput("t2_full_clear", BLOCK_W'(bus.fifo_full), BLOCK_W'(0));

    // Test 3: unrelated clocks, random writes, 1000 words against a reference queue
    resetDut();
    refQ.delete();
    sent = 0;
    blocks = 0;
    fork
      begin
        wcyc = 0;
        while (sent < 1000 && wcyc < 20000) begin
          @(negedge clk_wr);
          wcyc++;
          if ($urandom_range(1, 0) == 1) begin
            bus.wr_en   = 1'b1;
            bus.data_in = $urandom;
            if (bus.fifo_full === 1'b0) begin
              refQ.push_back(bus.data_in);
              sent++;
            end
          end else begin
            bus.wr_en = 1'b0;
          end
        end
        @(negedge clk_wr);
        bus.wr_en = 1'b0;
      end
      begin
        rcyc = 0;
        while (blocks < 62 && rcyc < 8000) begin
          @(negedge clk_rd);
          rcyc++;
          if (bus.block_ready === 1'b1 && bus.rd_en === 1'b0) begin
            expHdr = '0;
            for (int k = 0; k < WPB; k++) begin
              expHdr[(WPB-1-k)*WORD_W +: WORD_W] = (refQ.size() > 0) ? refQ.pop_front() : 'x;
            end
            checkOutput($sformatf("t3_blk%0d", blocks), bus.block_header, expHdr);
            blocks++;
            bus.rd_en = 1'b1;
          end else begin
            bus.rd_en = 1'b0;
          end
        end
        @(negedge clk_rd);
        bus.rd_en = 1'b0;
      end
    join
    checkOutput("t3_sent",   BLOCK_W'(sent),   BLOCK_W'(1000));
    checkOutput("t3_blocks", BLOCK_W'(blocks), BLOCK_W'(62));
    repeat (20) @(negedge clk_rd);
    checkOutput("t3_tail_fill",  BLOCK_W'(bus.fill_cnt),   BLOCK_W'(8));
    checkOutput("t3_tail_empty", BLOCK_W'(bus.fifo_empty), BLOCK_W'(1));

    // Test 4: slow writer, latency of fifo_empty after a single write
    wrHalf = 15000;
    rdHalf = 5000;
    resetDut();
    checkOutput("t4_empty_before", BLOCK_W'(bus.fifo_empty), BLOCK_W'(1));
    @(negedge clk_wr);
    bus.wr_en   = 1'b1;
    bus.data_in = 32'hA5A5_5A5A;
    @(posedge clk_wr);
    #1;
    bus.wr_en = 1'b0;
    n = 0;
    while (bus.fifo_empty === 1'b1 && n < 10) begin
      @(posedge clk_rd);
      #1;
      n++;
    end
    checkOutput("t4_empty_lat", BLOCK_W'(n >= 1 && n <= SYNC_STAGES + 1), BLOCK_W'(1));
    repeat (2) @(negedge clk_rd);
    checkOutput("t4_fill", BLOCK_W'(bus.fill_cnt), BLOCK_W'(1));
    checkOutput("t4_slot0", BLOCK_W'(bus.block_header[BLOCK_W-1 -: WORD_W]), BLOCK_W'(32'hA5A5_5A5A));
    wrHalf = 5000;
    rdHalf = 13514;

    // Test 5: reset with a partial block, then a fresh block
    resetDut();
    applyStimulus(32'h5000, 10);
    n = 0;
    while (bus.fill_cnt !== 5'd10 && n < 100) begin
      @(negedge clk_rd);
      n++;
    end
    checkOutput("t5_fill10", BLOCK_W'(bus.fill_cnt), BLOCK_W'(10));
    rst = 1'b1;
    #100;
    checkOutput("t5_full",  BLOCK_W'(bus.fifo_full),   BLOCK_W'(0));
    checkOutput("t5_drop",  BLOCK_W'(bus.wr_drop_cnt), BLOCK_W'(0));
    checkOutput("t5_hdr",   bus.block_header,          BLOCK_W'(0));
    checkOutput("t5_ready", BLOCK_W'(bus.block_ready), BLOCK_W'(0));
    checkOutput("t5_empty", BLOCK_W'(bus.fifo_empty),  BLOCK_W'(1));
    checkOutput("t5_fill",  BLOCK_W'(bus.fill_cnt),    BLOCK_W'(0));
    @(negedge clk_wr);
    rst = 1'b0;
    repeat (4) @(negedge clk_rd);
    applyStimulus(32'h7000, 16);
    waitReady("t5_ready2", 200);
    checkOutput("t5_fresh_hdr", bus.block_header, packSeq(32'h7000));

    // Test 6: rd_en held high throughout filling
    resetDut();
    bus.rd_en = 1'b1;
    applyStimulus(32'h600, 16);
    waitReady("t6_ready", 200);
    checkOutput("t6_hdr",  bus.block_header, packSeq(32'h600));
    checkOutput("t6_fill", BLOCK_W'(bus.fill_cnt), BLOCK_W'(0));
    @(negedge clk_rd);
    checkOutput("t6_consumed", BLOCK_W'(bus.block_ready), BLOCK_W'(0));
    bus.rd_en = 1'b0;
    repeat (3) @(negedge clk_rd);
    checkOutput("t6_empty", BLOCK_W'(bus.fifo_empty), BLOCK_W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
